slice_sequencer: RTL
====================

Name: slice_sequencer

Overview:
- Sequences a bit-field slice over one wide input word, emitting successive FIELD_WIDTH-bit fields one per handshake.
- Sits between a wide-word producer (e.g. a packetised bus or wide FIFO) and a narrow consumer.
- Replaces a bank of parallel fixed slices with one time-multiplexed, flow-controlled extractor.
- Field ordering runs from MSB or from LSB; the field count is programmable per word.

Parameters:
- INPUT_DATA_WIDTH, 32: width of the input word.
- FIELD_WIDTH, 8: width of each emitted field. INPUT_DATA_WIDTH must be an integer multiple of it.
- OFFSET_REL_TO_MSB, 1: 1 = field 0 is the top FIELD_WIDTH bits; 0 = field 0 is the bottom FIELD_WIDTH bits.
- MAX_FIELDS, INPUT_DATA_WIDTH/FIELD_WIDTH: fields per word.
- CW, clog2(MAX_FIELDS+1): width of the count and index ports.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_num_fields  input  CW  fields to emit for the next accepted word.
- in_data  input  INPUT_DATA_WIDTH  wide word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word.
- out_data  output  FIELD_WIDTH  current field.
- out_index  output  CW  index of the current field, starting at 0.
- out_last  output  1  current field is the final field of the word.
- out_valid  output  1  out_data, out_index and out_last are valid.
- out_ready  input  1  consumer accepts the current field.
- busy  output  1  a word is in progress.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - EMIT: in_ready=0, out_valid=1.
- Reset (asynchronous, immediate):
  - State goes to IDLE; the word register and count are cleared.
  - All outputs are 0, including in_ready.
  - On the first rising clk edge after rst deasserts, in_ready is registered to 1.
- Acceptance (IDLE, in_valid & in_ready at the edge):
  - Capture in_data and an effective count N.
  - N = MAX_FIELDS if cfg_num_fields == 0 or cfg_num_fields > MAX_FIELDS; otherwise N = cfg_num_fields.
  - Move to EMIT with index k=0; in_ready falls in the same edge.
  - cfg_num_fields is sampled only at acceptance and ignored at all other times.
- Field select:
  - MSB mode: out_data = word[INPUT_DATA_WIDTH-1-k*FIELD_WIDTH -: FIELD_WIDTH].
  - LSB mode: out_data = word[k*FIELD_WIDTH +: FIELD_WIDTH].
  - All outputs are registered.
- Latency: the first field is valid on the cycle after acceptance.
- Advance (EMIT, out_valid & out_ready at the edge):
  - If k < N-1: k increments and the next field presents on the next cycle.
  - If k == N-1: go to IDLE; out_valid=0 and in_ready=1 on the next cycle.
  - out_last = (k == N-1).
- Throughput with out_ready held high: N fields in N cycles, then one IDLE cycle. One word per N+1 cycles; no overlap between words.
- Backpressure: while out_valid & !out_ready, out_data, out_index and out_last hold stable. No field is skipped or duplicated.
- in_valid while in EMIT is ignored and has no side effect. The producer must hold its word until in_ready is high.
- busy = (state == EMIT).
- Reset asserted mid-word: the word is discarded and out_valid drops asynchronously. The next word after reset starts at index 0.
- No X propagation: out_data is 0 whenever out_valid is 0.

Test Plan:
- MSB mode, W=32, F=8, in_data=0xAABBCCDD, cfg=4, out_ready=1:
  - out_data = AA, BB, CC, DD on cycles 1-4 after acceptance, out_index 0-3.
  - out_last only with DD; in_ready=1 on cycle 5.
- LSB mode, same stimulus -> DD, CC, BB, AA, with out_last on AA.
- Backpressure: out_ready=0 for 3 cycles while field 1 is presented -> BB and index 1 held all 3 cycles; the CC and DD sequence is intact afterwards.
- Count boundaries (MSB mode):
  - cfg=0 -> 4 fields.
  - cfg=6 -> clamped to 4 fields.
  - cfg=1 -> single AA with out_last=1, then IDLE.
  - cfg changed mid-word -> no effect on the current word.
- Reset mid-word:
  - rst pulsed after 2 fields -> out_valid and busy drop to 0 immediately.
  - in_ready=0 until the first edge after release, then 1.
  - The next word 0x11223344 emits 11 at index 0.
- Back-to-back producer: in_valid held high with words 0x01020304 then 0x05060708 -> second word accepted only in IDLE; output is 01 02 03 04 05 06 07 08 with one bubble between words.

Source files
------------

// File: rtl/slice_sequencer.sv
// Time-multiplexed field extractor: captures one wide word and emits its
// FIELD_WIDTH-bit fields one per out_valid/out_ready handshake, MSB- or LSB-first.
module slice_sequencer #(
  parameter int unsigned INPUT_DATA_WIDTH  = 32,
  parameter int unsigned FIELD_WIDTH       = 8,
  parameter int unsigned OFFSET_REL_TO_MSB = 1,
  parameter int unsigned MAX_FIELDS        = INPUT_DATA_WIDTH / FIELD_WIDTH,
  parameter int unsigned CW                = $clog2(MAX_FIELDS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CW-1:0]               cfg_num_fields,
  input  logic [INPUT_DATA_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [FIELD_WIDTH-1:0]      out_data,
  output logic [CW-1:0]               out_index,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
);

  localparam int unsigned W  = INPUT_DATA_WIDTH;
  localparam int unsigned SW = $clog2(INPUT_DATA_WIDTH) + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t state, next_state;

  logic [W-1:0]           word_q, word_d;
  logic [CW-1:0]          k_q, k_d;
  logic [CW-1:0]          n_q, n_d;
  logic [CW-1:0]          eff_count;
  logic                   accept;
  logic                   at_last;
  logic                   in_ready_d;
  logic                   out_valid_d;
  logic [FIELD_WIDTH-1:0] out_data_d;
  logic [CW-1:0]          out_index_d;
  logic                   out_last_d;

  // Field k of a word, counted from the configured end.
  function automatic logic [FIELD_WIDTH-1:0] select_field(input logic [W-1:0] word,
                                                           input logic [CW-1:0] k);
    logic [SW-1:0] sh;
    logic [W-1:0]  t;
    sh = SW'(k) * SW'(FIELD_WIDTH);
    if (OFFSET_REL_TO_MSB != 0) begin
      t = word << sh;
      return t[W-1 -: FIELD_WIDTH];
    end else begin
      t = word >> sh;
      return t[FIELD_WIDTH-1:0];
    end
  endfunction

  // Zero or oversized requests fall back to a full word.
  always_comb begin
    eff_count = cfg_num_fields;
    if (cfg_num_fields == '0 || cfg_num_fields > CW'(MAX_FIELDS)) begin
      eff_count = CW'(MAX_FIELDS);
    end
  end

  assign accept  = (state == IDLE) && in_valid && in_ready;
  assign at_last = (k_q == n_q - CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = EMIT;
      EMIT:    if (out_ready && at_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next-cycle values for the datapath and every registered output.
  always_comb begin
    word_d = word_q;
    k_d    = k_q;
    n_d    = n_q;
    if (accept) begin
      word_d = in_data;
      k_d    = '0;
      n_d    = eff_count;
    end else if (state == EMIT && out_ready && !at_last) begin
      k_d = k_q + CW'(1);
    end

    in_ready_d  = (next_state == IDLE);
    out_valid_d = (next_state == EMIT);
    out_data_d  = '0;
    out_index_d = '0;
    out_last_d  = 1'b0;
    if (out_valid_d) begin
      out_data_d  = select_field(word_d, k_d);
      out_index_d = k_d;
      out_last_d  = (k_d == n_d - CW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q    <= '0;
      k_q       <= '0;
      n_q       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      word_q    <= word_d;
      k_q       <= k_d;
      n_q       <= n_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_index <= out_index_d;
      out_last  <= out_last_d;
    end
  end

  assign busy = (state == EMIT);

endmodule
